// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports with busy flags, two write ports, one issue port.
// The master drives addresses/writes/issues; the slave (register file) returns data and flags.
interface regfile_sb_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          iss_v;
    logic [AW-1:0] iss_rd;
    logic          busy1, busy2;
    logic          wcoll;

    modport master (
        output ra1, ra2, we0, we1, wa0, wa1, wd0, wd1, iss_v, iss_rd,
        input  rd1, rd2, busy1, busy2, wcoll
    );

    modport slave (
        input  ra1, ra2, we0, we1, wa0, wa1, wd0, wd1, iss_v, iss_rd,
        output rd1, rd2, busy1, busy2, wcoll
    );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with a per-entry busy scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 1
) (
    input logic        clk,
    input logic        rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             wcollQ;

    logic wrEn0, wrEn1, issEn;
    logic hit1w0, hit1w1, hit2w0, hit2w1;
    logic [DW-1:0] rd1Val, rd2Val;
    logic busy1Val, busy2Val;

    // Entry 0 swallows writes and issues when hard-wired to zero.
    assign wrEn0 = bus.we0   && !((ZERO_R0 != 0) && (bus.wa0    == '0));
    assign wrEn1 = bus.we1   && !((ZERO_R0 != 0) && (bus.wa1    == '0));
    assign issEn = bus.iss_v && !((ZERO_R0 != 0) && (bus.iss_rd == '0));

`ifdef RF_BYPASS_EN
    assign hit1w0 = wrEn0 && (bus.wa0 == bus.ra1);
    assign hit1w1 = wrEn1 && (bus.wa1 == bus.ra1);
    assign hit2w0 = wrEn0 && (bus.wa0 == bus.ra2);
    assign hit2w1 = wrEn1 && (bus.wa1 == bus.ra2);
`else
    assign hit1w0 = 1'b0;
    assign hit1w1 = 1'b0;
    assign hit2w0 = 1'b0;
    assign hit2w1 = 1'b0;
`endif

    // Issue is applied last so a new producer keeps the entry busy.
    always_comb begin
        busyNext = busy;
        if (wrEn0) busyNext[bus.wa0] = 1'b0;
        if (wrEn1) busyNext[bus.wa1] = 1'b0;
        if (issEn) busyNext[bus.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy   <= '0;
            wcollQ <= 1'b0;
        end else begin
            if (wrEn0) mem[bus.wa0] <= bus.wd0;
            // Port 1 is assigned second, so it wins a same-address collision.
            if (wrEn1) mem[bus.wa1] <= bus.wd1;
            busy   <= busyNext;
            wcollQ <= bus.we0 && bus.we1 && (bus.wa0 == bus.wa1);
        end
    end

    always_comb begin
        rd1Val   = '0;
        rd2Val   = '0;
        busy1Val = 1'b0;
        busy2Val = 1'b0;
        if (rst) begin
            if (hit1w1)      rd1Val = bus.wd1;
            else if (hit1w0) rd1Val = bus.wd0;
            else             rd1Val = mem[bus.ra1];
            if (hit2w1)      rd2Val = bus.wd1;
            else if (hit2w0) rd2Val = bus.wd0;
            else             rd2Val = mem[bus.ra2];
            busy1Val = busy[bus.ra1] && !(hit1w0 || hit1w1);
            busy2Val = busy[bus.ra2] && !(hit2w0 || hit2w1);
        end
    end

    assign bus.rd1   = rd1Val;
    assign bus.rd2   = rd2Val;
    assign bus.busy1 = busy1Val;
    assign bus.busy2 = busy2Val;
    assign bus.wcoll = wcollQ;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed cases followed by random traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int ZERO = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] refMem  [16];
    logic          refBusy [16];
    logic          refWcoll;

    regfile_sb_if #(.DW(DW), .AW(AW)) bus ();

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_R0(ZERO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            refMem[i]  = '0;
            refBusy[i] = 1'b0;
        end
        refWcoll = 1'b0;
    endtask

    function automatic logic bypassHit(input logic [AW-1:0] a, input logic we, input logic [AW-1:0] wa);
`ifdef RF_BYPASS_EN
        return we && (wa == a) && !(ZERO != 0 && a == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] expRd(input logic [AW-1:0] a);
        if (!rst) return '0;
        if (bypassHit(a, bus.we1, bus.wa1)) return bus.wd1;
        if (bypassHit(a, bus.we0, bus.wa0)) return bus.wd0;
        if (ZERO != 0 && a == 0) return '0;
        return refMem[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (!rst) return 1'b0;
        if (bypassHit(a, bus.we1, bus.wa1) || bypassHit(a, bus.we0, bus.wa0)) return 1'b0;
        if (ZERO != 0 && a == 0) return 1'b0;
        return refBusy[a];
    endfunction

    task automatic checkAll();
        chk("rd1",   bus.rd1,           expRd(bus.ra1));
        chk("rd2",   bus.rd2,           expRd(bus.ra2));
        chk("busy1", {31'b0, bus.busy1}, {31'b0, expBusy(bus.ra1)});
        chk("busy2", {31'b0, bus.busy2}, {31'b0, expBusy(bus.ra2)});
        chk("wcoll", {31'b0, bus.wcoll}, {31'b0, (rst ? refWcoll : 1'b0)});
    endtask

    // Sequential semantics: port 1 assigned after port 0, issue after writes.
    task automatic modelEdge();
        if (!rst) begin
            modelReset();
        end else begin
            if (bus.we0 && !(ZERO != 0 && bus.wa0 == 0)) begin
                refMem[bus.wa0]  = bus.wd0;
                refBusy[bus.wa0] = 1'b0;
            end
            if (bus.we1 && !(ZERO != 0 && bus.wa1 == 0)) begin
                refMem[bus.wa1]  = bus.wd1;
                refBusy[bus.wa1] = 1'b0;
            end
            if (bus.iss_v && !(ZERO != 0 && bus.iss_rd == 0)) refBusy[bus.iss_rd] = 1'b1;
            refWcoll = bus.we0 && bus.we1 && (bus.wa0 == bus.wa1);
        end
    endtask

    task automatic cyc();
        #1;
        checkAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.wa0 = '0;   bus.wa1 = '0;
        bus.wd0 = '0;   bus.wd1 = '0;
        bus.iss_v = 1'b0; bus.iss_rd = '0;
    endtask

    initial begin
        idle();
        bus.ra1 = '0; bus.ra2 = '0;
        modelReset();

        // Reset held: every address reads zero and not busy.
        #2;
        for (int a = 0; a < 16; a++) begin
            bus.ra1 = 4'(a);
            bus.ra2 = 4'(15 - a);
            #1;
            chk("rst_rd1", bus.rd1, '0);
            chk("rst_rd2", bus.rd2, '0);
            chk("rst_busy", {30'b0, bus.busy1, bus.busy2}, '0);
            chk("rst_wcoll", {31'b0, bus.wcoll}, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            bus.ra1 = 4'(a);
            bus.ra2 = 4'(a);
            #0.2;
            chk("post_rst_rd1", bus.rd1, '0);
            chk("post_rst_busy2", {31'b0, bus.busy2}, '0);
        end
        @(posedge clk);
        #1;

        // Same-address dual write: port 1 wins, wcoll pulses for one cycle.
        bus.we0 = 1'b1; bus.wa0 = 4'd3; bus.wd0 = 32'hA5A5A5A5;
        bus.we1 = 1'b1; bus.wa1 = 4'd3; bus.wd1 = 32'h12345678;
        bus.ra1 = 4'd3;
        cyc();
        idle();
        #1;
        chk("coll_rd1", bus.rd1, 32'h12345678);
        chk("coll_wcoll1", {31'b0, bus.wcoll}, 32'd1);
        cyc();
        #1;
        chk("coll_wcoll0", {31'b0, bus.wcoll}, 32'd0);

        // Entry 0 is hard-wired to zero and never busy.
        bus.we0 = 1'b1; bus.wa0 = 4'd0; bus.wd0 = 32'hFFFFFFFF;
        bus.iss_v = 1'b1; bus.iss_rd = 4'd0;
        bus.ra1 = 4'd0;
        cyc();
        idle();
        #1;
        chk("r0_rd1", bus.rd1, '0);
        chk("r0_busy1", {31'b0, bus.busy1}, '0);

        // Scoreboard set, issue-beats-write, then write clears.
        bus.iss_v = 1'b1; bus.iss_rd = 4'd5;
        bus.ra2 = 4'd5;
        cyc();
        idle();
        #1;
        chk("sb_set", {31'b0, bus.busy2}, 32'd1);
        bus.we0 = 1'b1; bus.wa0 = 4'd5; bus.wd0 = 32'h00000055;
        bus.iss_v = 1'b1; bus.iss_rd = 4'd5;
        cyc();
        idle();
        #1;
        chk("sb_issue_wins", {31'b0, bus.busy2}, 32'd1);
        bus.we0 = 1'b1; bus.wa0 = 4'd5; bus.wd0 = 32'h00000066;
        cyc();
        idle();
        #1;
        chk("sb_clear", {31'b0, bus.busy2}, 32'd0);

        // Read-during-write on address 7.
        bus.we1 = 1'b1; bus.wa1 = 4'd7; bus.wd1 = 32'h11110000;
        cyc();
        idle();
        bus.ra1 = 4'd7;
        bus.we0 = 1'b1; bus.wa0 = 4'd7; bus.wd0 = 32'hCAFEF00D;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_same_cycle", bus.rd1, 32'hCAFEF00D);
`else
        chk("byp_same_cycle", bus.rd1, 32'h11110000);
`endif
        cyc();
        idle();
        #1;
        chk("byp_next_cycle", bus.rd1, 32'hCAFEF00D);

        // Asynchronous reset between edges wipes a freshly written entry.
        bus.we1 = 1'b1; bus.wa1 = 4'd9; bus.wd1 = 32'h00000001;
        bus.iss_v = 1'b1; bus.iss_rd = 4'd9;
        bus.ra1 = 4'd9; bus.ra2 = 4'd9;
        cyc();
        idle();
        #1;
        chk("pre_rst_rd1", bus.rd1, 32'h00000001);
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        chk("async_rst_rd1", bus.rd1, '0);
        chk("async_rst_busy2", {31'b0, bus.busy2}, '0);
        bus.we0 = 1'b1; bus.wa0 = 4'd9; bus.wd0 = 32'hDEADBEEF;
        bus.iss_v = 1'b1; bus.iss_rd = 4'd9;
        cyc();
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_rd1", bus.rd1, '0);
        chk("rst_release_busy1", {31'b0, bus.busy1}, '0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            bus.we0    = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.wa0    = 4'($urandom_range(0, 15));
            bus.wa1    = ($urandom_range(0, 3) == 0) ? bus.wa0 : 4'($urandom_range(0, 15));
            bus.wd0    = $urandom;
            bus.wd1    = $urandom;
            bus.iss_v  = ($urandom_range(0, 2) == 0);
            bus.iss_rd = 4'($urandom_range(0, 15));
            bus.ra1    = ($urandom_range(0, 3) == 0) ? bus.wa0 : 4'($urandom_range(0, 15));
            bus.ra2    = ($urandom_range(0, 3) == 0) ? bus.wa1 : 4'($urandom_range(0, 15));
            cyc();
        end
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DW, default 32, data width in bits.
REQ-002 SHALL provide parameter AW, default 4, address width; depth = 2**AW entries.
REQ-003 SHALL provide parameter ZERO_R0, default 1, entry 0 hard-wired to zero when 1.
REQ-004 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide ports ra1, ra2  input  AW  read addresses.
REQ-007 SHALL provide ports rd1, rd2  output  DW  read data.
REQ-008 SHALL provide ports we0, we1  input  1  write enables, ports 0 and 1.
REQ-009 SHALL provide ports wa0, wa1  input  AW  write addresses.
REQ-010 SHALL provide ports wd0, wd1  input  DW  write data.
REQ-011 SHALL provide port iss_v  input  1  issue valid; marks iss_rd pending.
REQ-012 SHALL provide port iss_rd  input  AW  destination being issued.
REQ-013 SHALL provide ports busy1, busy2  output  1  pending flag of ra1/ra2.
REQ-014 SHALL provide port wcoll  output  1  registered flag: previous cycle had a same-address dual write.

Function
REQ-015 Storage SHALL be 2**AW x DW; writes occur on rising clk edge.
REQ-016 Reads SHALL be combinational from storage (subject to REQ-027).
REQ-017 When ZERO_R0=1, writes to address 0 SHALL be dropped, reads of address 0 return 0, busy of address 0 reads 0, and issue to 0 does not set busy.
REQ-018 we0 and we1 to different addresses SHALL both commit in the same cycle.
REQ-019 we0 and we1 to the same address SHALL commit wd1 only (port 1 priority) and set wcoll=1 on the following cycle; otherwise wcoll=0.
REQ-020 Scoreboard SHALL hold one busy bit per entry.
REQ-021 iss_v=1 SHALL set busy[iss_rd] at the next edge.
REQ-022 An enabled write to address a SHALL clear busy[a] at the next edge.
REQ-023 Issue and write to the same address in the same cycle SHALL leave busy=1 (issue wins; new producer).
REQ-024 Issue to an already-busy entry SHALL keep it busy, with no error.
REQ-025 busy1/busy2 SHALL reflect registered scoreboard state combinationally; no same-cycle write clears them.
REQ-026 Write-address and read-address ranges SHALL need no bounds check; all AW values are legal.

Reset
REQ-027 rst=0 SHALL asynchronously clear all storage entries, all busy bits and wcoll to 0.
REQ-028 During reset rd1/rd2 SHALL read 0, busy1/busy2 0, and writes/issues SHALL be ignored.
REQ-029 Reset deassertion SHALL take effect at the first rising clk edge with rst=1; no other init sequence.
REQ-030 Reset asserted mid-write SHALL win; the entry SHALL read 0 after reset.

Configuration
REQ-031 Macro RF_BYPASS_EN defined: a read whose address matches an enabled same-cycle write (nonzero when ZERO_R0=1) SHALL return the write data (wd1 over wd0 on dual match), and the matching busy output SHALL read 0.
REQ-032 RF_BYPASS_EN undefined: reads SHALL return stored value only; new data visible one cycle after the write; busy outputs per REQ-025.

Verification
REQ-033 Reset then read all addresses -> rd1=rd2=0, busy1=busy2=0, wcoll=0.
REQ-034 we0 wa0=3 wd0=0xA5A5A5A5 and we1 wa1=3 wd1=0x12345678 -> next cycle ra1=3 gives 0x12345678, wcoll=1; following idle cycle wcoll=0.
REQ-035 Write wa0=0 wd0=0xFFFFFFFF with ZERO_R0=1 -> ra1=0 returns 0; iss_rd=0 -> busy1=0.
REQ-036 iss_v iss_rd=5; next cycle ra2=5 -> busy2=1; same cycle as we0 wa0=5 plus iss_v iss_rd=5 -> busy2 stays 1; write alone -> busy2=0 next cycle.
REQ-037 Bypass: ra1=7 with we0 wa0=7 wd0=0xCAFEF00D same cycle -> with RF_BYPASS_EN rd1=0xCAFEF00D immediately; without, rd1=old value, 0xCAFEF00D next cycle.
REQ-038 Write wa1=9 wd1=0x1, pulse rst=0 between clock edges -> rd1 at ra1=9 becomes 0 immediately and stays 0 after release.
